// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default bus widths, fetch FSM states, the halt
// sentinel word and the fetch buffer entry layout.
package cpu_pkg;

    localparam int unsigned CPU_ADDR_W = 32;
    localparam int unsigned CPU_DATA_W = 32;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    // All-ones instruction word stops fetching when the halt feature is built in
    localparam logic [CPU_DATA_W-1:0] HALT_WORD = '1;

    typedef struct packed {
        logic [CPU_DATA_W-1:0] instr;
        logic [CPU_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry synchronous FIFO of fetch entries, organised as a shift pair so
// the head register keeps its last value once the FIFO drains or is flushed.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   push        - write push_data (ignored when full unless popping)
//   push_data   - entry to append
//   pop         - remove head (ignored when empty)
//   flush       - empty the FIFO; wins over push
//   count       - number of valid entries (0..2)
//   head        - oldest entry
module fetch_buf
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    logic [1:0]   count_q, count_d;
    fetch_entry_t e0_q, e0_d;
    fetch_entry_t e1_q, e1_d;
    logic         do_push, do_pop;
    logic [1:0]   slot;

    // Next-state for the entry pair and occupancy
    always_comb begin
        do_pop  = pop && (count_q != 2'd0);
        do_push = push && ((count_q != 2'd2) || do_pop);
        slot    = count_q - 2'(do_pop);
        count_d = count_q;
        e0_d    = e0_q;
        e1_d    = e1_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            if (do_pop && (count_q == 2'd2)) begin
                e0_d = e1_q;
            end
            if (do_push) begin
                if (slot == 2'd0) begin
                    e0_d = push_data;
                end else begin
                    e1_d = push_data;
                end
            end
            count_d = count_q + 2'(do_push) - 2'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            e0_q    <= '0;
            e1_q    <= '0;
        end else begin
            count_q <= count_d;
            e0_q    <= e0_d;
            e1_q    <= e1_d;
        end
    end

    assign count = count_q;
    assign head  = e0_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, requests the shared RAM port, captures
// fetched words into a two-entry buffer and presents them to decode with a
// valid/ready handshake. Branch redirects flush the buffer and reload the PC.
// Optional build macro FETCH_HALT_EN: an all-ones fetched word stops fetching
// until the next redirect.
// Ports:
//   clk, rst_n                       - clock, synchronous active-low reset
//   mem_pc, mem_fetch_req            - RAM instruction address / port request
//   mem_gnt, mem_fetch               - port grant / word returned for mem_pc
//   br_valid, br_target              - redirect pulse and new PC
//   instr, instr_pc, instr_valid     - head instruction toward decode
//   instr_ready                      - decode accepts head
//   halted                           - fetch stopped by halt word
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = CPU_ADDR_W,
    parameter int unsigned       DATA_W   = CPU_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       PC_STEP  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] mem_pc,
    output logic              mem_fetch_req,
    input  logic              mem_gnt,
    input  logic [DATA_W-1:0] mem_fetch,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              halted
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [1:0]        buf_count;
    fetch_entry_t      buf_head;
    fetch_entry_t      push_data;
    logic              capture;
    logic              pop;
    logic              halt_capture;

    // A redirect in the same cycle cancels the capture
    always_comb begin
        capture   = mem_fetch_req && mem_gnt && !br_valid;
        pop       = instr_valid && instr_ready;
        push_data = '{instr: mem_fetch, pc: pc_q};
`ifdef FETCH_HALT_EN
        halt_capture = capture && (mem_fetch == HALT_WORD);
`else
        halt_capture = 1'b0;
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (halt_capture) state_d = HALT;
            HALT:    state_d = HALT;
            default: state_d = BOOT;
        endcase
        if (br_valid) begin
            state_d = RUN;
        end
    end

    // Output logic: a full buffer can still take a word if the head leaves
    always_comb begin
        mem_fetch_req = 1'b0;
        halted        = 1'b0;
        if (state_q == RUN) begin
            mem_fetch_req = (buf_count != 2'd2) || instr_ready;
        end
`ifdef FETCH_HALT_EN
        halted = (state_q == HALT);
`endif
    end

    // Program counter
    always_comb begin
        pc_d = pc_q;
        if (br_valid) begin
            pc_d = br_target;
        end else if (capture) begin
            pc_d = pc_q + ADDR_W'(PC_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_buf u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (capture),
        .push_data (push_data),
        .pop       (pop),
        .flush     (br_valid),
        .count     (buf_count),
        .head      (buf_head)
    );

    assign mem_pc      = pc_q;
    assign instr_valid = (buf_count != 2'd0);
    assign instr       = buf_head.instr;
    assign instr_pc    = buf_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

`ifdef FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] mem_pc;
    logic        mem_fetch_req;
    logic        mem_gnt;
    logic [31:0] mem_fetch;
    logic        br_valid;
    logic [31:0] br_target;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        halted;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_pc        (mem_pc),
        .mem_fetch_req (mem_fetch_req),
        .mem_gnt       (mem_gnt),
        .mem_fetch     (mem_fetch),
        .br_valid      (br_valid),
        .br_target     (br_target),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .halted        (halted)
    );

    // Program image: halt words at 5 and 0x45, elsewhere never all-ones
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h5 || a == 32'h45) return 32'hFFFF_FFFF;
        return {a[15:0], a[15:0] ^ 16'hA5C3};
    endfunction

    assign mem_fetch = mem_word(mem_pc);

    // Reference model: queue of delivered-to-be words, PC, and mode flags
    typedef struct {
        logic [31:0] i;
        logic [31:0] p;
    } ent_t;

    ent_t        q[$];
    ent_t        m_last;
    logic [31:0] m_pc;
    bit          m_boot;
    bit          m_halt;
    bit          m_known = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock: drive at negedge, check model vs DUT, advance model at posedge
    task automatic step(input bit rst, input bit g, input bit r, input bit b, input logic [31:0] t);
        bit   exp_req;
        bit   do_pop;
        ent_t e;
        @(negedge clk);
        rst_n       = rst;
        mem_gnt     = g;
        instr_ready = r;
        br_valid    = b;
        br_target   = t;
        #1;
        exp_req = !m_boot && !m_halt && (q.size() < 2 || r);
        if (m_known) begin
            cmp("instr_valid", 32'(instr_valid), 32'(q.size() > 0));
            cmp("instr", instr, (q.size() > 0) ? q[0].i : m_last.i);
            cmp("instr_pc", instr_pc, (q.size() > 0) ? q[0].p : m_last.p);
            cmp("mem_fetch_req", 32'(mem_fetch_req), 32'(exp_req));
            cmp("mem_pc", mem_pc, m_pc);
            cmp("halted", 32'(halted), 32'(HALT_EN && m_halt));
        end
        @(posedge clk);
        if (!rst) begin
            q.delete();
            m_pc    = 32'h0;
            m_boot  = 1'b1;
            m_halt  = 1'b0;
            m_last  = '{i: 32'h0, p: 32'h0};
            m_known = 1'b1;
        end else if (m_known) begin
            if (b) begin
                q.delete();
                m_pc   = t;
                m_boot = 1'b0;
                m_halt = 1'b0;
            end else begin
                do_pop = (q.size() > 0) && r;
                if (do_pop) void'(q.pop_front());
                if (exp_req && g) begin
                    e.i = mem_word(m_pc);
                    e.p = m_pc;
                    q.push_back(e);
                    m_pc = m_pc + 32'd1;
                    if (HALT_EN && e.i == 32'hFFFF_FFFF) m_halt = 1'b1;
                end
                m_boot = 1'b0;
            end
            if (q.size() > 0) m_last = q[0];
        end
        #1;
    endtask

    task automatic run(input int n, input bit g, input bit r);
        for (int k = 0; k < n; k++) step(1'b1, g, r, 1'b0, 32'h0);
    endtask

    initial begin
        logic [31:0] tgt;
        bit          rr, gg, bb, rs;
        rst_n = 1'b0; mem_gnt = 1'b1; instr_ready = 1'b1; br_valid = 1'b0; br_target = '0;

        // Reset and first-fetch latency
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        cmp("pin rst valid", 32'(instr_valid), 32'h0);
        cmp("pin rst instr", instr, 32'h0);
        cmp("pin rst req", 32'(mem_fetch_req), 32'h0);
        run(1, 1'b1, 1'b1);
        cmp("pin boot valid", 32'(instr_valid), 32'h0);
        for (int k = 0; k < 4; k++) begin
            run(1, 1'b1, 1'b1);
            cmp("pin stream valid", 32'(instr_valid), 32'h1);
            cmp("pin stream pc", instr_pc, 32'(k));
        end

        // Back-pressure from reset: buffer fills with pc 0,1 and fetch stalls
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        run(1, 1'b1, 1'b0);
        run(5, 1'b1, 1'b0);
        cmp("pin full req", 32'(mem_fetch_req), 32'h0);
        cmp("pin full mem_pc", mem_pc, 32'h2);
        cmp("pin full head", instr_pc, 32'h0);
        run(1, 1'b1, 1'b1);
        cmp("pin drain1", instr_pc, 32'h1);
        run(1, 1'b1, 1'b1);
        cmp("pin drain2", instr_pc, 32'h2);

        // Grant withheld: PC holds, stream resumes without duplicates
        run(3, 1'b0, 1'b1);
        cmp("pin nogrant mem_pc", mem_pc, 32'h4);
        cmp("pin nogrant valid", 32'(instr_valid), 32'h0);
        run(1, 1'b1, 1'b1);
        cmp("pin resume pc", instr_pc, 32'h4);

        // Halt word at address 5
        run(1, 1'b1, 1'b1);
        cmp("pin halt word", instr, 32'hFFFF_FFFF);
        cmp("pin halt pc", instr_pc, 32'h5);
        cmp("pin halt mem_pc", mem_pc, 32'h6);
        cmp("pin halted", 32'(halted), 32'(HALT_EN));
        run(1, 1'b1, 1'b1);
        if (HALT_EN) begin
            cmp("pin halt drained", 32'(instr_valid), 32'h0);
            cmp("pin halt hold", mem_pc, 32'h6);
        end else begin
            cmp("pin after halt word", instr_pc, 32'h6);
        end
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h8);
        cmp("pin br halted", 32'(halted), 32'h0);
        cmp("pin br mem_pc", mem_pc, 32'h8);
        run(1, 1'b1, 1'b1);
        cmp("pin br first", instr_pc, 32'h8);

        // Redirect while full with a grant outstanding
        run(1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h40);
        cmp("pin flush valid", 32'(instr_valid), 32'h0);
        run(1, 1'b1, 1'b1);
        cmp("pin redirect 40", instr_pc, 32'h40);
        run(1, 1'b1, 1'b1);
        cmp("pin redirect 41", instr_pc, 32'h41);

        // PC wrap
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
        run(1, 1'b1, 1'b1);
        cmp("pin wrap top", instr_pc, 32'hFFFF_FFFF);
        run(1, 1'b1, 1'b1);
        cmp("pin wrap zero", instr_pc, 32'h0);

        // Randomised traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rs = ($urandom_range(0, 199) != 0);
            gg = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 3) != 0);
            bb = ($urandom_range(0, 29) == 0);
            case ($urandom_range(0, 2))
                0:       tgt = 32'($urandom_range(0, 15));
                1:       tgt = 32'h40 + 32'($urandom_range(0, 8));
                default: tgt = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
            endcase
            step(rs, gg, rr, bb, tgt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
